spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//   SPI responder: the far end of the team's SPI master. Oversamples SCLK/CS_N/MOSI
//   in the system clock domain, deserialises MOSI into bytes, serialises queued TX
//   bytes onto MISO. Parallel side uses a valid/ready TX handshake and a 1-cycle RX pulse.
//   Used as a loopback target for master verification and as a config-port front end.
// PARAMETERS
//   DATA_W     8     bits per SPI word
//   CPOL       0     SCLK idle level
//   CPHA       0     0: sample on leading edge; 1: sample on trailing edge
//   MSB_FIRST  1     1: MSB shifted first; 0: LSB first
//   DEFAULT_TX 8'hFF word shifted out when the TX buffer is empty (underrun)
// PORTS
//   clk          in   1       system clock; must be >= 8x SCLK
//   rst_n        in   1       asynchronous active-low reset
//   sclk         in   1       SPI clock (async to clk)
//   cs_n         in   1       SPI chip select, active low (async)
//   mosi         in   1       SPI data in (async)
//   miso         out  1       SPI data out
//   miso_oe      out  1       MISO output enable (1 while CS asserted)
//   tx_data      in   DATA_W  next word to transmit
//   tx_valid     in   1       tx_data valid
//   tx_ready     out  1       1-entry TX buffer empty; transfer when valid&ready
//   rx_data      out  DATA_W  last complete received word (held until next word)
//   rx_valid     out  1       1-cycle pulse, rx_data updated
//   tx_underrun  out  1       1-cycle pulse, DEFAULT_TX loaded because buffer empty
//   busy         out  1       CS asserted (synchronised)
// BEHAVIOUR
//   - Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0,
//     busy=0; bit counter, shift regs, TX buffer cleared. Async assert, sync release.
//   - Inputs pass 2-FF synchronisers; edges detected on registered copies: an input
//     change is acted on 3 clk later. Leading edge = SCLK leaving CPOL; trailing = returning.
//   - States IDLE / ACTIVE. IDLE->ACTIVE on synchronised cs_n fall; ACTIVE->IDLE on rise.
//     busy and miso_oe follow state; SCLK edges ignored in IDLE.
//   - Word-start event: CPHA=0: CS fall, and the trailing edge after the DATA_W-th
//     sample; CPHA=1: leading edge with bit_cnt==0. At word-start, TX shift reg loads
//     the buffer (buffer cleared, tx_ready=1 next cycle), or DEFAULT_TX + tx_underrun
//     pulse if empty. First bit is on miso the cycle after the event.
//   - Shift edge (non-sample edge) advances MISO; sample edge shifts MOSI in, bit_cnt++.
//   - On DATA_W-th sample: rx_data <= word, rx_valid=1 next cycle, bit_cnt wraps to 0.
//     No RX backpressure; unread words are overwritten.
//   - TX write accepted in the same cycle as a word-start event goes to the buffer,
//     not the shift reg (used for the following word).
//   - CS rise mid-word: partial RX word discarded (no rx_valid), bit_cnt=0, TX shift
//     reg cleared; TX buffer contents retained. miso=0 when miso_oe=0.
//   - Reset mid-word: all state per reset list; no rx_valid emitted.
// STRUCTURE
//   - spi_defs.vh: CPOL/CPHA mode encodings, state encodings (IDLE, ACTIVE).
//   - Sub-module spi_sync: 2-FF synchroniser + previous-value register, one per async input.
//   - Main body: state reg, bit counter, TX buffer, TX/RX shift regs.
// TESTING
//   1. Mode 0, tx 8'hA5 queued, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1;
//      rx_data=8'h3C with one rx_valid pulse; tx_ready=1 after CS fall.
//   2. Empty buffer, master sends 8'h00 -> miso=8'hFF, one tx_underrun pulse.
//   3. 3-word burst, tx_valid refilled per tx_ready -> 3 rx_valid pulses, TX words in
//      order, no underrun.
//   4. CS rise after 5 bits, then new 8-bit frame 8'h81 -> no rx_valid for partial,
//      rx_data=8'h81 after second frame.
//   5. Repeat 1 for CPOL/CPHA=1/1 and MSB_FIRST=0 -> same words, bit order reversed.
//   6. rst_n low mid-word -> all outputs at reset values within 1 clk, no rx_valid.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder: FSM states and the
// index map of the synchronised SPI inputs.
package spi_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SYNC_N    = 3;
  localparam int SYNC_SCLK = 0;
  localparam int SYNC_CS   = 1;
  localparam int SYNC_MOSI = 2;

  // Reset value for each synchroniser lane, chosen so reset never looks like an edge.
  function automatic logic sync_rst_val(input int idx, input int cpol);
    if (idx == SYNC_CS)   return 1'b1;
    if (idx == SYNC_SCLK) return (cpol != 0);
    return 1'b0;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// 2-FF synchroniser for one asynchronous input, plus a registered copy of
// the synchronised value for edge detection.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic dprev
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= RST_VAL;
      dout  <= RST_VAL;
      dprev <= RST_VAL;
    end else begin
      meta  <= din;
      dout  <= meta;
      dprev <= dout;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_N/MOSI in the clk domain, deserialises
// MOSI into words and serialises a 1-entry buffered TX word onto MISO.
module spi_slave import spi_slave_pkg::*; #(
  parameter int                DATA_W     = 8,
  parameter int                CPOL       = 0,
  parameter int                CPHA       = 0,
  parameter int                MSB_FIRST  = 1,
  parameter logic [DATA_W-1:0] DEFAULT_TX = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int   CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int   OUT_BIT  = (MSB_FIRST != 0) ? DATA_W - 1 : 0;
  localparam logic IDLE_LVL = (CPOL != 0);

  // Reset asserts asynchronously but releases on a clk edge.
  logic rst_q1, rst_s_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_s_n, rst_q1} <= 2'b00;
    else        {rst_s_n, rst_q1} <= {rst_q1, 1'b1};
  end

  logic [SYNC_N-1:0] raw, syn, prv;
  assign raw = {mosi, cs_n, sclk};

  for (genvar i = 0; i < SYNC_N; i++) begin : g_sync
    spi_sync #(.RST_VAL(sync_rst_val(i, CPOL))) u_sync (
      .clk   (clk),
      .rst_n (rst_s_n),
      .din   (raw[i]),
      .dout  (syn[i]),
      .dprev (prv[i])
    );
  end

  logic unused_mosi_prev;
  assign unused_mosi_prev = prv[SYNC_MOSI];

  spi_state_e state, state_nxt;
  logic              cs_fall, cs_rise, lead, trail, in_word;
  logic              sample, shft, word_start, shift_adv;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_nxt, tx_buf;
  logic              buf_full;

  assign cs_fall = prv[SYNC_CS] & ~syn[SYNC_CS];
  assign cs_rise = ~prv[SYNC_CS] & syn[SYNC_CS];
  assign lead    = (prv[SYNC_SCLK] == IDLE_LVL) && (syn[SYNC_SCLK] != IDLE_LVL);
  assign trail   = (prv[SYNC_SCLK] != IDLE_LVL) && (syn[SYNC_SCLK] == IDLE_LVL);
  assign in_word = (state == ST_ACTIVE) && !cs_rise;
  assign sample  = in_word && ((CPHA != 0) ? trail : lead);
  assign shft    = in_word && ((CPHA != 0) ? lead : trail);

  // A shift edge seen with bit_cnt==0 is always a word boundary: in CPHA=0
  // it is the trailing edge after the last sample, in CPHA=1 the first edge.
  assign word_start = ((CPHA == 0) && (state == ST_IDLE) && cs_fall) ||
                      (shft && (bit_cnt == '0));
  assign shift_adv  = shft && (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_nxt = rx_sr;
    if (MSB_FIRST != 0) rx_nxt = {rx_sr[DATA_W-2:0], syn[SYNC_MOSI]};
    else                rx_nxt = {syn[SYNC_MOSI], rx_sr[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (tx_valid && !buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
      if (cs_rise && (state == ST_ACTIVE)) begin
        bit_cnt <= '0;
        tx_sr   <= '0;
        rx_sr   <= '0;
      end else begin
        if (word_start) begin
          if (buf_full) begin
            tx_sr    <= tx_buf;
            buf_full <= 1'b0;
          end else begin
            tx_sr       <= DEFAULT_TX;
            tx_underrun <= 1'b1;
          end
        end else if (shift_adv) begin
          tx_sr <= (MSB_FIRST != 0) ? (tx_sr << 1) : (tx_sr >> 1);
        end
        if (sample) begin
          rx_sr <= rx_nxt;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            bit_cnt  <= '0;
            rx_data  <= rx_nxt;
            rx_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign busy     = (state == ST_ACTIVE);
  assign miso_oe  = busy;
  assign miso     = miso_oe & tx_sr[OUT_BIT];
  assign tx_ready = ~buf_full;

endmodule
